serial_add_seq: RTL

Bit-serial adder sequencer that computes a WIDTH-bit unsigned sum using a single one-bit full-adder slice, one bit per clock. The slice is two `half_adder_behav` instances plus an OR for carry merge, so the block is the controller that time-shares the team's half-adder cell across every operand bit. It sits between a requesting master (start/done handshake) and the shared bit slice, trading latency for area.

---
 rtl/serial_add_seq.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/serial_add_seq.sv
// serial_add_seq
// Bit-serial unsigned adder. It computes a WIDTH-bit sum one bit per clock,
// starting at the LSB. A single full-adder slice is built from two
// half_adder_behav cells and an OR that merges their carries. That one slice
// is reused for every operand bit, which keeps the datapath small at the
// cost of latency.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      operation request; only taken in IDLE
//   a, b       operands; captured on the accepting edge only
//   sum        registered result (a+b mod 2^WIDTH); held until the next completion
//   carry_out  registered carry out of bit WIDTH-1; held together with sum
//   busy       high in RUN and DONE
//   done       one-cycle completion strobe
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; operands are captured on the accepting edge
// RUN    | one operand bit per edge, LSB first, through the shared slice
// DONE   | sum/carry_out just updated; done strobe; back to IDLE next edge

module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic ha0_s, ha0_c;
  logic ha1_s, ha1_c;
  logic carry_next;
  logic last_bit;

  // Shared one-bit full-adder slice.
  half_adder_behav u_ha0 (
    .a_i (opa_q[0]),
    .b_i (opb_q[0]),
    .s_o (ha0_s),
    .c_o (ha0_c)
  );

  half_adder_behav u_ha1 (
    .a_i (ha0_s),
    .b_i (carry_q),
    .s_o (ha1_s),
    .c_o (ha1_c)
  );

  assign carry_next = ha0_c | ha1_c;
  assign last_bit   = (cnt_q == LAST_BIT);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: both outputs decode the state register only, so no
  // input reaches them combinationally.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      S_RUN:   busy = 1'b1;
      S_DONE:  begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath next values
  always_comb begin
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          res_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        // Each new sum bit enters at the MSB, so after WIDTH shifts bit 0
        // has landed in position 0.
        res_d   = {ha1_s, res_q[WIDTH-1:1]};
        carry_d = carry_next;
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          // Publish the fully shifted result, including the bit computed
          // on this edge.
          sum_d  = {ha1_s, res_q[WIDTH-1:1]};
          cout_d = carry_next;
        end
      end
      default: begin
        opa_d = opa_q;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule

// half_adder_behav
// Behavioural half adder cell shared across the bit-serial datapath.
//   a_i, b_i  input bits
//   s_o       sum bit
//   c_o       carry bit
module half_adder_behav (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule
